// File: rtl/paddle_input_conditioner.sv
// paddle_input_conditioner
// Synchronises and debounces the four paddle push-buttons, resolves each
// player's up/down pair into a direction, and issues one registered move
// strobe per frame_tick while a direction is held.
// Optional feature: define PADDLE_ACCEL_EN to build the per-player held-frame
// counters that drive pa_fast/pb_fast; otherwise both flags are constant 0.
// Button vector order everywhere: {A_up, A_down, B_up, B_down}, MSB first.

module paddle_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int ACCEL_FRAMES    = 30
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       PlayerA_up,
  input  logic       PlayerA_down,
  input  logic       PlayerB_up,
  input  logic       PlayerB_down,
  output logic       pa_up,
  output logic       pa_down,
  output logic       pb_up,
  output logic       pb_down,
  output logic       pa_fast,
  output logic       pb_fast,
  output logic [3:0] btn_state
);

  // Direction FSM encoding, shared by both players.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_HOLD_UP   = 2'd1;
  localparam logic [1:0] ST_HOLD_DOWN = 2'd2;

  // Count value at which a differing level is accepted.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       raw_btn;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       db_q, db_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Index 0 is player A, index 1 is player B.
  logic [1:0]       up_lvl, dn_lvl;
  logic [1:0]       state_q [2];
  logic [1:0]       state_d [2];
  logic [1:0]       up_q, up_d;
  logic [1:0]       dn_q, dn_d;

  assign raw_btn = {PlayerA_up, PlayerA_down, PlayerB_up, PlayerB_down};
  assign up_lvl  = {db_q[1], db_q[3]};
  assign dn_lvl  = {db_q[0], db_q[2]};

  // Two-flop synchroniser chain for the asynchronous buttons.
  always_comb begin
    sync1_d = raw_btn;
    sync2_d = sync1_q;
  end

  // Debounce: count consecutive cycles where the synchronised level differs
  // from the accepted level; accept it on the DEBOUNCE_CYCLES-th such cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Direction select and strobe generation; the FSM only moves on frame_tick
  // and reads the registered debounced levels.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      up_d[p]    = 1'b0;
      dn_d[p]    = 1'b0;
      if (frame_tick) begin
        case ({up_lvl[p], dn_lvl[p]})
          2'b10:   state_d[p] = ST_HOLD_UP;
          2'b01:   state_d[p] = ST_HOLD_DOWN;
          default: state_d[p] = ST_IDLE;  // conflicting or no press
        endcase
        up_d[p] = (state_d[p] == ST_HOLD_UP);
        dn_d[p] = (state_d[p] == ST_HOLD_DOWN);
      end
    end
  end

  // Synchroniser, debouncer and direction state registers.
  always_ff @(posedge pixel_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      up_q    <= '0;
      dn_q    <= '0;
      // NOTE: the counter array is four small registers, not a RAM, so it is
      // reset element by element like any other flop.
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      for (int p = 0; p < 2; p++) state_q[p] <= ST_IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      for (int p = 0; p < 2; p++) state_q[p] <= state_d[p];
    end
  end

`ifdef PADDLE_ACCEL_EN
  localparam int              HOLD_W   = $clog2(ACCEL_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(ACCEL_FRAMES);

  logic [HOLD_W-1:0] held_q [2];
  logic [HOLD_W-1:0] held_d [2];
  logic [1:0]        fast_q, fast_d;

  // Held-frame counter: load 1 on entering a hold, count up (saturating)
  // while the same hold persists, clear on IDLE; fast follows the new count.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      held_d[p] = held_q[p];
      fast_d[p] = 1'b0;
      if (frame_tick) begin
        if (state_d[p] == ST_IDLE) begin
          held_d[p] = '0;
        end else if (state_d[p] == state_q[p]) begin
          held_d[p] = (held_q[p] == HOLD_SAT) ? held_q[p]
                                              : held_q[p] + HOLD_W'(1);
        end else begin
          held_d[p] = HOLD_W'(1);
        end
        fast_d[p] = (state_d[p] != ST_IDLE) && (held_d[p] >= HOLD_SAT);
      end
    end
  end

  // Held-frame counter and fast-flag registers.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      fast_q <= '0;
      for (int p = 0; p < 2; p++) held_q[p] <= '0;
    end else begin
      fast_q <= fast_d;
      for (int p = 0; p < 2; p++) held_q[p] <= held_d[p];
    end
  end

  assign pa_fast = fast_q[0];
  assign pb_fast = fast_q[1];
`else
  assign pa_fast = 1'b0;
  assign pb_fast = 1'b0;
`endif

  assign pa_up     = up_q[0];
  assign pa_down   = dn_q[0];
  assign pb_up     = up_q[1];
  assign pb_down   = dn_q[1];
  assign btn_state = db_q;

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Self-checking bench for paddle_input_conditioner: directed scenarios plus a
// randomized phase, all compared every cycle against a frame-level model.
// Define PADDLE_ACCEL_EN for both files to exercise the fast flags.

module tb_paddle_input_conditioner;

  localparam int DB = 4;
  localparam int CW = 3;
  localparam int AF = 3;

  logic       pixel_clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       PlayerA_up, PlayerA_down, PlayerB_up, PlayerB_down;
  logic       pa_up, pa_down, pb_up, pb_down, pa_fast, pb_fast;
  logic [3:0] btn_state;

  paddle_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CW),
    .ACCEL_FRAMES   (AF)
  ) dut (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .PlayerA_up  (PlayerA_up),
    .PlayerA_down(PlayerA_down),
    .PlayerB_up  (PlayerB_up),
    .PlayerB_down(PlayerB_down),
    .pa_up       (pa_up),
    .pa_down     (pa_down),
    .pb_up       (pb_up),
    .pb_down     (pb_down),
    .pa_fast     (pa_fast),
    .pb_fast     (pb_fast),
    .btn_state   (btn_state)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Observation counters for the directed scenarios.
  int n_pa_up, n_pa_dn, n_pb_up, n_pb_dn, n_pa_fast, n_both, n_bs3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce as a sliding window: a button's accepted level flips when the
  // last DB synchronised samples all disagree with it. Direction per player:
  // 0 none, 1 up, 2 down, re-evaluated on each frame_tick.
  logic [3:0] m_s1, m_s2, m_db, m_strb;
  logic [1:0] m_fast;               // {pa_fast, pb_fast}
  logic [3:0] hist[$];
  int         m_dir[2];
  int         m_held[2];

  task automatic model_edge(input logic r, input logic [3:0] raw, input logic ft);
    logic [3:0] db_old;
    logic       all_diff;
    logic       u, d;
    int         nd;
    m_strb = '0;
    m_fast = '0;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      hist.delete();
      for (int p = 0; p < 2; p++) begin m_dir[p] = 0; m_held[p] = 0; end
    end else begin
      db_old = m_db;
      hist.push_back(m_s2);
      if (hist.size() > DB) void'(hist.pop_front());
      m_s2 = m_s1;
      m_s1 = raw;
      if (hist.size() == DB) begin
        for (int i = 0; i < 4; i++) begin
          all_diff = 1'b1;
          foreach (hist[k]) if (hist[k][i] == db_old[i]) all_diff = 1'b0;
          if (all_diff) m_db[i] = ~db_old[i];
        end
      end
      if (ft) begin
        for (int p = 0; p < 2; p++) begin
          u  = db_old[3 - 2*p];
          d  = db_old[2 - 2*p];
          nd = (u && !d) ? 1 : (d && !u) ? 2 : 0;
          if (nd == 0)               m_held[p] = 0;
          else if (nd == m_dir[p])   m_held[p] = m_held[p] + 1;
          else                       m_held[p] = 1;
          m_dir[p] = nd;
          m_strb[3 - 2*p] = (nd == 1);
          m_strb[2 - 2*p] = (nd == 2);
`ifdef PADDLE_ACCEL_EN
          m_fast[1 - p] = (nd != 0) && (m_held[p] >= AF);
`endif
        end
      end
    end
  endtask

  // One clock: drive on the falling edge, model the rising edge, sample 1 ns later.
  task automatic step(input logic r, input logic [3:0] raw, input logic ft);
    @(negedge pixel_clk);
    reset      = r;
    {PlayerA_up, PlayerA_down, PlayerB_up, PlayerB_down} = raw;
    frame_tick = ft;
    @(posedge pixel_clk);
    model_edge(r, raw, ft);
    #1;
    check("btn_state", btn_state, m_db);
    check("strobes",   {pa_up, pa_down, pb_up, pb_down}, m_strb);
    check("fast",      {pa_fast, pb_fast}, m_fast);
    n_pa_up   += pa_up;
    n_pa_dn   += pa_down;
    n_pb_up   += pb_up;
    n_pb_dn   += pb_down;
    n_pa_fast += pa_fast;
    n_both    += (pa_up & pb_down);
    n_bs3     += btn_state[3];
    cyc++;
  endtask

  // Free-running phase with frame_tick every 20 cycles.
  task automatic run(input int n, input logic [3:0] raw);
    for (int k = 0; k < n; k++) step(1'b0, raw, (cyc % 20) == 19);
  endtask

  task automatic align(input logic [3:0] raw);
    while ((cyc % 20) != 0) step(1'b0, raw, (cyc % 20) == 19);
  endtask

  task automatic clear_counts();
    n_pa_up = 0; n_pa_dn = 0; n_pb_up = 0; n_pb_dn = 0;
    n_pa_fast = 0; n_both = 0; n_bs3 = 0;
  endtask

  initial begin
    logic [3:0] rr;
    logic       ft;
    int         first_f;
    logic [6:0] bounce;

    reset = 1'b1; frame_tick = 1'b0;
    {PlayerA_up, PlayerA_down, PlayerB_up, PlayerB_down} = '0;
    clear_counts();

    // Reset with all buttons pressed, then measure time to 4'b1111.
    for (int k = 0; k < 3; k++) step(1'b1, 4'hF, 1'b0);
    check("reset_outputs", {pa_up, pa_down, pb_up, pb_down, pa_fast, pb_fast, btn_state}, 10'd0);
    first_f = -1;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'hF, (cyc % 20) == 19);
      if (first_f < 0 && btn_state == 4'hF) first_f = k;
    end
    check("reset_latency", first_f, 5);

    // Bounce on A_up: 2 high, 1 low, 3 high, then low.
    step(1'b1, 4'h0, 1'b0);
    step(1'b1, 4'h0, 1'b0);
    clear_counts();
    bounce = 7'b1101110;
    for (int k = 6; k >= 0; k--) step(1'b0, {bounce[k], 3'b000}, (cyc % 20) == 19);
    run(40, 4'h0);
    check("bounce_btn", n_bs3, 0);
    check("bounce_strobe", n_pa_up, 0);

    // Hold A_down across five ticks.
    align(4'h0);
    clear_counts();
    run(101, 4'b0100);
    check("hold_pa_down", n_pa_dn, 5);
    check("hold_pa_up", n_pa_up, 0);
    run(40, 4'h0);

    // Conflict on player B, then release B_down.
    align(4'h0);
    clear_counts();
    run(60, 4'b0011);
    check("conflict_strobes", n_pb_up + n_pb_dn, 0);
    align(4'b0011);
    clear_counts();
    run(21, 4'b0010);
    check("conflict_release", n_pb_up, 1);
    run(40, 4'h0);

    // Independence: A_up and B_down together.
    align(4'h0);
    clear_counts();
    run(101, 4'b1001);
    check("indep_pa_up", n_pa_up, 5);
    check("indep_pb_down", n_pb_dn, 5);
    check("indep_same_cycle", n_both, 5);
    run(40, 4'h0);

    // Acceleration: five held frames, one released frame, press again.
    align(4'h0);
    clear_counts();
    run(101, 4'b1000);
    check("accel_strobes", n_pa_up, 5);
`ifdef PADDLE_ACCEL_EN
    check("accel_fast", n_pa_fast, 3);
`else
    check("accel_fast", n_pa_fast, 0);
`endif
    align(4'h0);
    clear_counts();
    run(41, 4'b1000);
    check("accel_restart_strobes", n_pa_up, 2);
    check("accel_restart_fast", n_pa_fast, 0);
    run(40, 4'h0);

    // Randomized phase: bouncy buttons, irregular and back-to-back ticks,
    // occasional reset.
    rr = '0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) rr[$urandom_range(0, 3)] = ~rr[$urandom_range(0, 3)];
      if ($urandom_range(0, 5) == 0) rr ^= 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      ft = ($urandom_range(0, 4) == 0);
      step(($urandom_range(0, 599) == 0), rr, ft);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
